// File: rtl/perc_vote_if.sv
// perc_vote_if: result handshake between the vote stage and its consumer
interface perc_vote_if #(parameter int WIN_W = 4);
   logic result_valid, result_ready, result;
   logic [WIN_W-1:0] act_count;
   modport master (output result_valid, result, act_count, input result_ready);
   modport slave (input result_valid, result, act_count, output result_ready);
endinterface

// File: rtl/perc_vote.sv
// perc_vote: strict-majority vote over a programmable window of perceptron decisions
module perc_vote #(parameter int WIN_W = 4) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIN_W-1:0] win_len,
   input  logic             act_valid,
   input  logic             act_in,
   output logic             busy,
   perc_vote_if.master      res
);
   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
   state_t state;
   logic [WIN_W-1:0] len, seen, cnt, seen_n, cnt_n;
   logic valid, verdict;
   always_comb begin
      seen_n = seen + 1'b1;
      cnt_n  = cnt + WIN_W'(act_in);
   end
   assign res.result_valid = valid;
   assign res.result       = verdict;
   assign res.act_count    = cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         len     <= '0;
         seen    <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         valid   <= 1'b0;
         verdict <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start && win_len != '0) begin
               len   <= win_len;
               seen  <= '0;
               cnt   <= '0;
               busy  <= 1'b1;
               state <= COLLECT;
            end
            COLLECT: if (act_valid) begin
               seen <= seen_n;
               cnt  <= cnt_n;
               if (seen_n == len) begin
                  // 2*count > len in WIN_W+1 bits: ties vote inactive
                  state   <= HOLD;
                  valid   <= 1'b1;
                  verdict <= {cnt_n, 1'b0} > {1'b0, len};
               end
            end
            HOLD: if (res.result_ready) begin
               state <= IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/perc_vote.md
Name: perc_vote

Overview:
- Downstream stage of the 8-input perceptron.
- Consumes the perceptron's 1-bit active/inactive decision, one sample per valid cycle, over a programmable window.
- Produces a registered majority verdict plus the active count, handed off to the next consumer through a valid/ready handshake.

Parameters:
- WIN_W, 4, width of window length and counters; maximum window 2^WIN_W-1 samples.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a window; honoured only in IDLE.
- win_len  input  WIN_W  window length in samples; sampled with start; 0 is illegal and the start is ignored.
- act_valid  input  1  act_in carries a decision this cycle.
- act_in  input  1  perceptron decision (1 = active).
- busy  output  1  high in COLLECT and HOLD.
- result_valid  output  1  result and act_count are valid.
- result_ready  input  1  consumer accepts the result.
- result  output  1  majority verdict.
- act_count  output  WIN_W  number of active samples in the window.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, result_valid=0, result=0, act_count=0.
  - Internal seen counter and latched length cleared.
  - Takes effect immediately, including mid-window or mid-HOLD. Partial window discarded, no result produced.
- All outputs are registered.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - start=1 and win_len!=0 at a rising edge: latch len=win_len, clear seen and act_count, go to COLLECT.
  - start with win_len=0: ignored, stay IDLE.
  - act_valid ignored.
- COLLECT:
  - Each edge with act_valid=1: seen+=1; act_count+=1 if act_in=1.
  - The edge that accepts the sample making seen==len goes to HOLD.
  - That same edge sets result_valid=1 and result=(2*act_count_final > len), computed in WIN_W+1 bits, with act_count_final including the last sample.
  - Tie (e.g. 2 of 4): result=0, i.e. strict majority.
  - act_valid=0 cycles stall; there is no timeout.
  - start ignored.
- HOLD:
  - result_valid=1; result and act_count held stable.
  - act_valid and start ignored; samples arriving in HOLD are dropped.
  - Edge with result_ready=1 goes to IDLE and clears result_valid.
  - result and act_count keep their last values until the next start.
  - result_ready while result_valid=0 has no effect.
- Latency:
  - result_valid rises in the cycle after the edge that samples the final act_valid.
  - Minimum window of len=1 with start at edge k and sample at edge k+1: result_valid high after edge k+1.
- Back-to-back operation:
  - Accepting the result (HOLD to IDLE) and a new start cannot share an edge.
  - The earliest new start is honoured on the edge after acceptance.
- Counter bounds: act_count ≤ seen ≤ len ≤ 2^WIN_W-1, so no wrap-around is possible.
- busy = (state != IDLE).

Test Plan:
- Reset then idle: rst_n low 3 cycles, release; toggle act_valid/act_in 5 cycles with no start -> busy=0, result_valid=0, act_count=0 throughout.
- Clear majority: start with win_len=5; samples 1,1,0,1,0 with act_valid every cycle -> result_valid rises the cycle after the 5th sample; act_count=3, result=1. Hold result_ready=0 for 4 cycles -> outputs stable. Assert result_ready -> result_valid=0 and busy=0 next cycle.
- Tie and stalls: start with win_len=4; samples 1,0,1,0 interleaved with act_valid=0 gaps of 2 cycles -> act_count=2, result=0; samples during gaps not counted.
- Illegal and ignored requests: start with win_len=0 -> stays IDLE, busy=0. Then start with win_len=3; pulse start again mid-window with win_len=7 -> window still ends after 3 samples. Samples sent in HOLD -> act_count unchanged.
- Maximum window: WIN_W=4, win_len=15, all samples act_in=1 -> act_count=15, result=1, no wrap. Repeat with all 0 -> act_count=0, result=0.
- Reset mid-operation: start with win_len=6, 3 active samples, assert rst_n low asynchronously between edges -> busy, result_valid and act_count go to 0 immediately. After release, a new window of win_len=2 with samples 1,1 -> act_count=2, result=1; no residue from the aborted window.
